// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount as coins, largest denomination first.
// Ports: clk/reset (async, active high); start/amount/abort from the vending FSM;
//   coin_valid/coin_type/coin_ready handshake to the ejector; busy/done/aborted/err status;
//   remaining/residue/counts ({dollars,quarters,dimes,nickels}) for the display path.
// Latency: start edge -> first coin offer after 2 edges. Backpressure: the offer holds until coin_ready.
module change_dispenser #(
   parameter int MAX_AMOUNT = 500,
   parameter int GAP_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [8:0]  amount,
   input  logic        abort,
   output logic        coin_valid,
   output logic [1:0]  coin_type,
   input  logic        coin_ready,
   output logic        busy,
   output logic        done,
   output logic        aborted,
   output logic        err,
   output logic [8:0]  remaining,
   output logic [2:0]  residue,
   output logic [15:0] counts
);

   typedef enum logic [2:0] {S_IDLE, S_SELECT, S_OFFER, S_GAP, S_FINISH} state_t;

   // The gap counter is loaded with GAP_CYCLES-1 and counts down to zero, so it
   // only ever needs to hold GAP_CYCLES-1.
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [9:0] MAX_L = 10'(MAX_AMOUNT);

   function automatic logic [8:0] denom_val(input logic [1:0] t);
      case (t)
         2'd0:    return 9'd100;
         2'd1:    return 9'd25;
         2'd2:    return 9'd10;
         default: return 9'd5;
      endcase
   endfunction

   state_t        state_q, state_d;
   logic          coin_valid_q, coin_valid_d;
   logic [1:0]    coin_type_q, coin_type_d;
   logic          aborted_q, aborted_d;
   logic          err_q, err_d;
   logic [8:0]    remaining_q, remaining_d;
   logic [2:0]    residue_q, residue_d;
   logic [15:0]   counts_q, counts_d;
   logic [GW-1:0] gap_q, gap_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         coin_valid_q <= 1'b0;
         coin_type_q  <= 2'd0;
         aborted_q    <= 1'b0;
         err_q        <= 1'b0;
         remaining_q  <= 9'd0;
         residue_q    <= 3'd0;
         counts_q     <= 16'd0;
         gap_q        <= '0;
      end else begin
         state_q      <= state_d;
         coin_valid_q <= coin_valid_d;
         coin_type_q  <= coin_type_d;
         aborted_q    <= aborted_d;
         err_q        <= err_d;
         remaining_q  <= remaining_d;
         residue_q    <= residue_d;
         counts_q     <= counts_d;
         gap_q        <= gap_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      coin_valid_d = coin_valid_q;
      coin_type_d  = coin_type_q;
      aborted_d    = aborted_q;
      err_d        = 1'b0;
      remaining_d  = remaining_q;
      residue_d    = residue_q;
      counts_d     = counts_q;
      gap_d        = gap_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if ({1'b0, amount} > MAX_L) begin
                  err_d = 1'b1;
               end else begin
                  state_d     = S_SELECT;
                  remaining_d = amount;
                  counts_d    = 16'd0;
                  aborted_d   = 1'b0;
                  residue_d   = 3'(amount % 9'd5);
               end
            end
         end

         S_SELECT: begin
            if (abort) begin
               state_d   = S_FINISH;
               aborted_d = 1'b1;
            end else if (remaining_q < 9'd5) begin
               state_d = S_FINISH;
            end else begin
               // Greedy choice; the chosen value never exceeds remaining_q.
               if (remaining_q >= 9'd100)     coin_type_d = 2'd0;
               else if (remaining_q >= 9'd25) coin_type_d = 2'd1;
               else if (remaining_q >= 9'd10) coin_type_d = 2'd2;
               else                           coin_type_d = 2'd3;
               coin_valid_d = 1'b1;
               state_d      = S_OFFER;
            end
         end

         S_OFFER: begin
            if (coin_ready) begin
               remaining_d  = remaining_q - denom_val(coin_type_q);
               case (coin_type_q)
                  2'd0:    counts_d[15:12] = counts_q[15:12] + 4'd1;
                  2'd1:    counts_d[11:8]  = counts_q[11:8]  + 4'd1;
                  2'd2:    counts_d[7:4]   = counts_q[7:4]   + 4'd1;
                  default: counts_d[3:0]   = counts_q[3:0]   + 4'd1;
               endcase
               coin_valid_d = 1'b0;
               if (abort) begin
                  // The coin already left: count it, then stop.
                  state_d   = S_FINISH;
                  aborted_d = 1'b1;
               end else if (GAP_CYCLES == 0) begin
                  state_d = S_SELECT;
               end else begin
                  state_d = S_GAP;
                  gap_d   = GAP_LOAD;
               end
            end else if (abort) begin
               // Withdraw the pending offer without counting it.
               coin_valid_d = 1'b0;
               state_d      = S_FINISH;
               aborted_d    = 1'b1;
            end
         end

         S_GAP: begin
            if (abort) begin
               state_d   = S_FINISH;
               aborted_d = 1'b1;
            end else if (gap_q == '0) begin
               state_d = S_SELECT;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end

         S_FINISH: state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

   assign coin_valid = coin_valid_q;
   assign coin_type  = coin_type_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_FINISH);
   assign aborted    = aborted_q;
   assign err        = err_q;
   assign remaining  = remaining_q;
   assign residue    = residue_q;
   assign counts     = counts_q;

endmodule
